// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU control block and its multiply/divide
// unit: aluctl encodings, aluop classes, R-type funct codes, the MD sequencer
// state type and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU operation encodings driven onto aluctl
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  // Main-decoder ALU classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_BR    = 2'b11;

  // R-type funct codes: plain ALU
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  // R-type funct codes: multiply/divide and HI/LO moves
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // R-type funct -> ALU operation; anything unlisted falls back to ADD
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    logic [3:0] r;
    r = ALU_ADD;
    case (f)
      F_ADD, F_ADDU: r = ALU_ADD;
      F_SUB, F_SUBU: r = ALU_SUB;
      F_AND:         r = ALU_AND;
      F_OR:          r = ALU_OR;
      F_XOR:         r = ALU_XOR;
      F_NOR:         r = ALU_NOR;
      F_SLT:         r = ALU_SLT;
      F_SLTU:        r = ALU_SLTU;
      F_SLL:         r = ALU_SLL;
      F_SRL:         r = ALU_SRL;
      F_SRA:         r = ALU_SRA;
      default:       r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Ops that start the iterative unit
  function automatic logic is_md_start(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // Any op that touches HI/LO (must wait while the unit is occupied)
  function automatic logic is_md_any(input logic [5:0] f);
    return is_md_start(f) || (f == F_MFHI) || (f == F_MTHI) ||
           (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/alu_control_mc_if.sv
// -----------------------------------------------------------------------------
// alu_control_mc_if
// Bundles the EX-stage control/operand inputs and the ALU-control / HI-LO
// outputs of alu_control_mc.
//   master: pipeline side (drives aluop, funct, issue, flush, rs_val, rt_val)
//   slave : alu_control_mc (drives aluctl, busy, stall, done, hi, lo, hilo_sel)
// -----------------------------------------------------------------------------
interface alu_control_mc_if #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
);
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic             issue;
  logic             flush;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [CTL_W-1:0] aluctl;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             hilo_sel;

  modport master (
    output aluop, funct, issue, flush, rs_val, rt_val,
    input  aluctl, busy, stall, done, hi, lo, hilo_sel
  );

  modport slave (
    input  aluop, funct, issue, flush, rs_val, rt_val,
    output aluctl, busy, stall, done, hi, lo, hilo_sel
  );
endinterface

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative multiply/divide datapath: operand registers, step counter and the
// per-cycle shift-add (multiply) or restoring-subtract (divide) step on
// unsigned magnitudes, plus combinational sign correction of the result.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              latch operands/mode, counter <= WIDTH
//   step              perform one iteration, counter - 1
//   clr               abandon the operation (counter <= 0)
//   signed_op, is_div operation mode sampled on load
//   a, b              rs (multiplicand/dividend), rt (multiplier/divisor)
//   last              current step is the final one (counter == 1)
//   res_hi, res_lo    sign-corrected result, valid after the final step
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             clr,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // acc_reg: partial product high half / partial remainder
  // q_reg  : multiplier shifting out / dividend shifting out, quotient in
  // m_reg  : multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_reg, q_reg, m_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             div_reg, neg_q_reg, neg_r_reg, div0_reg;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // One multiply step: conditionally add, then shift {acc,q} right
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] acc_mul, q_mul;
  assign mul_sum = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
  assign acc_mul = mul_sum[WIDTH:1];
  assign q_mul   = {mul_sum[0], q_reg[WIDTH-1:1]};

  // One restoring-divide step. The partial remainder is always below the
  // divisor, so shifted < 2*divisor and the top bit of diff is a clean borrow.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_div, q_div;
  assign div_shift = {acc_reg, q_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_reg};
  assign div_ge    = ~div_diff[WIDTH];
  assign acc_div   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign q_div     = {q_reg[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      div0_reg  <= 1'b0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      acc_reg   <= '0;
      q_reg     <= a_mag;
      m_reg     <= b_mag;
      cnt_reg   <= CNT_W'(WIDTH);
      div_reg   <= is_div;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      div0_reg  <= is_div && (b == '0);
    end else if (step) begin
      acc_reg <= div_reg ? acc_div : acc_mul;
      q_reg   <= div_reg ? q_div : q_mul;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign last = (cnt_reg == CNT_W'(1));

  // Sign correction. Divide by zero leaves the dividend magnitude in acc, so
  // restoring its sign returns rs_val in hi; lo is forced to all ones.
  // Most-negative / -1 falls out naturally: the magnitude quotient 2^(W-1)
  // negates back to itself and the remainder is zero.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_reg, q_reg};
  assign prod_fix = neg_q_reg ? (~prod + 1'b1) : prod;
  assign quo_fix  = div0_reg ? '1 : (neg_q_reg ? (~q_reg + 1'b1) : q_reg);
  assign rem_fix  = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;

  assign res_hi = div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = div_reg ? quo_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_control_mc.sv
// -----------------------------------------------------------------------------
// alu_control_mc
// EX-stage ALU control: combinational aluctl decode plus a multi-cycle
// multiply/divide sequencer owning the HI/LO registers.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus (slave) aluop/funct/issue/flush/rs_val/rt_val in;
//               aluctl/busy/stall/done/hi/lo/hilo_sel out
// An MD op is accepted only while idle; while the unit runs, any HI/LO op
// stalls EX, other ops flow through untouched.
// -----------------------------------------------------------------------------
module alu_control_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_control_mc_if.slave   bus
);
  md_state_t        state_reg, state_next;
  logic [3:0]       ctl_enc;
  logic             is_rtype, md_any, md_start, start_ok;
  logic             busy, mdu_load, mdu_step, write_res;
  logic             mdu_last;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg;
  logic             move_ok;

  // ---------------- ALU operation decode ----------------
  always_comb begin
    ctl_enc = ALU_ADD;
    case (bus.aluop)
      ALUOP_ADD:   ctl_enc = ALU_ADD;
      ALUOP_SUB:   ctl_enc = ALU_SUB;
      ALUOP_BR:    ctl_enc = ALU_SUB;
      ALUOP_RTYPE: ctl_enc = funct_decode(bus.funct);
      default:     ctl_enc = ALU_ADD;
    endcase
  end

  assign bus.aluctl = CTL_W'(ctl_enc);

  assign is_rtype = (bus.aluop == ALUOP_RTYPE);
  assign md_any   = is_rtype && is_md_any(bus.funct);
  assign md_start = is_rtype && is_md_start(bus.funct);
  assign start_ok = bus.issue && md_start && !bus.flush;

  // ---------------- sequencer: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- sequencer: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.flush)     state_next = ST_IDLE;
        else if (mdu_last) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- sequencer: outputs ----------------
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    mdu_load  = (state_reg == ST_IDLE) && start_ok;
    mdu_step  = (state_reg == ST_RUN) && !bus.flush;
    write_res = (state_reg == ST_FIX) && !bus.flush;
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mdu_load),
    .step      (mdu_step),
    .clr       (bus.flush),
    .signed_op ((bus.funct == F_MULT) || (bus.funct == F_DIV)),
    .is_div    ((bus.funct == F_DIV) || (bus.funct == F_DIVU)),
    .a         (bus.rs_val),
    .b         (bus.rt_val),
    .last      (mdu_last),
    .res_hi    (mdu_hi),
    .res_lo    (mdu_lo)
  );

  // ---------------- HI/LO and done ----------------
  // mthi/mtlo write only when the unit is idle (otherwise they are stalled)
  assign move_ok = bus.issue && !busy && !bus.flush && is_rtype;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= write_res;
      if (write_res) begin
        hi_reg <= mdu_hi;
        lo_reg <= mdu_lo;
      end else if (move_ok && (bus.funct == F_MTHI)) begin
        hi_reg <= bus.rs_val;
      end else if (move_ok && (bus.funct == F_MTLO)) begin
        lo_reg <= bus.rs_val;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.stall    = bus.issue && busy && md_any;
  assign bus.done     = done_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.hilo_sel = is_rtype && (bus.funct == F_MFHI);

endmodule

// File: tb/tb_alu_control_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_control_mc
// Directed plus randomized checks of alu_control_mc (WIDTH=32) against a
// behavioural model using plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_control_mc;
  localparam int WIDTH = 32;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_control_mc_if #(.WIDTH(WIDTH), .CTL_W(4)) bus ();

  alu_control_mc #(.WIDTH(WIDTH), .CTL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // aluctl expected from the opcode tables
  function automatic logic [3:0] exp_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op != 2'b10) return (op == 2'b00) ? 4'b0010 : 4'b0110;
    case (f)
      6'b100000, 6'b100001: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b0100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b0101;
      6'b000000: return 4'b1000;
      6'b000010: return 4'b1001;
      6'b000011: return 4'b1010;
      default:   return 4'b0010;
    endcase
  endfunction

  // {hi, lo} by plain 64-bit arithmetic (SV division truncates toward zero)
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (f == MULT)  return 64'(sa * sb);
    if (f == MULTU) return 64'(ua * ub);
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (f == DIV) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic drive_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.aluop  = 2'b10;
    bus.funct  = f;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.issue  = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.issue = 1'b0;
    bus.aluop = 2'b00;
    bus.funct = 6'b100000;
  endtask

  // Issue one MD op and check latency, done pulse and result
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          n;
    e = ref_md(f, a, b);
    n = 0;
    drive_md(f, a, b);
    #1;
    chk({tag, "_stall_idle"}, 64'(bus.stall), 64'(0));
    tick();
    idle_inputs();
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(WIDTH + 1));
    chk({tag, "_done"}, 64'(bus.done), 64'(1));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
    $display("%s f=%b rs=%h rt=%h -> hi=%h lo=%h", tag, f, a, b, bus.hi, bus.lo);
    tick();
    chk({tag, "_done_clr"}, 64'(bus.done), 64'(0));
  endtask

  logic [5:0]  flist [0:14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                6'b000000, 6'b000010, 6'b000011, 6'b111111, 6'b011000};
  logic [5:0]  mdops [0:3] = '{MULT, MULTU, DIV, DIVU};

  initial begin
    logic [63:0] e;
    logic [31:0] a, b, hi0, lo0;
    logic [5:0]  f;
    int          n;

    bus.flush  = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    idle_inputs();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    rst_n = 1'b1;

    // first op accepted at the first edge after reset release
    run_md("mult_7_m3", MULT, 32'd7, 32'hFFFF_FFFD);

    // ---- aluctl sweep ----
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 15; i++) begin
        bus.aluop = 2'(op);
        bus.funct = flist[i];
        #1;
        chk("aluctl", 64'(bus.aluctl), 64'(exp_ctl(2'(op), flist[i])));
        $display("aluop=%b funct=%b aluctl=%b", bus.aluop, bus.funct, bus.aluctl);
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus.aluop = 2'b10;
      bus.funct = 6'($urandom);
      #1;
      chk("aluctl_rand", 64'(bus.aluctl), 64'(exp_ctl(2'b10, bus.funct)));
      $display("aluop=10 funct=%b aluctl=%b", bus.funct, bus.aluctl);
    end
    bus.aluop = 2'b10;
    bus.funct = MFHI;
    #1;
    chk("hilo_sel_mfhi", 64'(bus.hilo_sel), 64'(1));
    bus.funct = MFLO;
    #1;
    chk("hilo_sel_mflo", 64'(bus.hilo_sel), 64'(0));
    idle_inputs();
    tick();

    // ---- directed divides ----
    run_md("divu_100_7", DIVU, 32'd100, 32'd7);
    run_md("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
    run_md("div_5_0", DIV, 32'd5, 32'd0);
    run_md("div_m5_0", DIV, 32'hFFFF_FFFB, 32'd0);
    run_md("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // ---- randomized MD ops ----
    for (int i = 0; i < 16; i++) begin
      f = mdops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      run_md("rand", f, a, b);
    end

    // ---- stall behaviour while busy ----
    e = ref_md(DIVU, 32'd100, 32'd7);
    drive_md(DIVU, 32'd100, 32'd7);
    tick();
    idle_inputs();
    tick();
    tick();
    bus.aluop = 2'b00;
    bus.issue = 1'b1;
    #1;
    chk("add_busy_stall", 64'(bus.stall), 64'(0));
    chk("add_busy_aluctl", 64'(bus.aluctl), 64'(4'b0010));
    $display("add while busy: stall=%b", bus.stall);
    bus.aluop  = 2'b10;
    bus.funct  = MTHI;
    bus.rs_val = 32'hDEAD_BEEF;
    #1;
    chk("mthi_busy_stall", 64'(bus.stall), 64'(1));
    tick();
    bus.funct = MFLO;
    n = 0;
    while (bus.busy && n < 200) begin
      #1;
      chk("mflo_busy_stall", 64'(bus.stall), 64'(1));
      n++;
      tick();
    end
    chk("mflo_stall_release", 64'(bus.stall), 64'(0));
    chk("stall_op_done", 64'(bus.done), 64'(1));
    chk("stall_op_hi", 64'(bus.hi), 64'(e[63:32]));
    chk("stall_op_lo", 64'(bus.lo), 64'(e[31:0]));
    $display("mflo stalled %0d cycles, hi=%h lo=%h", n, bus.hi, bus.lo);
    idle_inputs();
    tick();

    // ---- mthi / mtlo while idle ----
    a = $urandom;
    b = $urandom;
    bus.aluop  = 2'b10;
    bus.funct  = MTHI;
    bus.rs_val = a;
    bus.issue  = 1'b1;
    tick();
    bus.funct  = MTLO;
    bus.rs_val = b;
    tick();
    idle_inputs();
    chk("mthi", 64'(bus.hi), 64'(a));
    chk("mtlo", 64'(bus.lo), 64'(b));
    $display("mthi/mtlo: hi=%h lo=%h", bus.hi, bus.lo);

    // ---- flush at RUN cycle 10 ----
    hi0 = bus.hi;
    lo0 = bus.lo;
    drive_md(MULT, $urandom, $urandom);
    tick();
    idle_inputs();
    repeat (9) tick();
    chk("flush_pre_busy", 64'(bus.busy), 64'(1));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'(0));
    for (int i = 0; i < 40; i++) begin
      chk("flush_no_done", 64'(bus.done), 64'(0));
      tick();
    end
    chk("flush_hi", 64'(bus.hi), 64'(hi0));
    chk("flush_lo", 64'(bus.lo), 64'(lo0));
    $display("flush: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    // flush overrides a simultaneous issue
    drive_md(DIVU, 32'd9, 32'd3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle_inputs();
    chk("flush_issue_busy", 64'(bus.busy), 64'(0));
    run_md("after_flush", MULTU, $urandom, $urandom);

    // ---- asynchronous reset at RUN cycle 10 ----
    drive_md(DIV, $urandom, $urandom);
    tick();
    idle_inputs();
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_done", 64'(bus.done), 64'(0));
    chk("arst_hi", 64'(bus.hi), 64'(0));
    chk("arst_lo", 64'(bus.lo), 64'(0));
    $display("async reset mid-op: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    tick();
    rst_n = 1'b1;
    run_md("after_rst", DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
